// File: rtl/iram_arbiter_if.sv
// Bundle of the fetch port, the load/store port and the RAM macro pins.
// slave: arbiter view; master: core/RAM side view (stimulus, models).
interface iram_arbiter_if #(
  parameter int XLEN     = 32,
  parameter int ADDR_LEN = 14
);
  logic                  i_req;
  logic [ADDR_LEN-1:0]   i_addr;
  logic                  i_gnt;
  logic                  i_rvalid;
  logic [XLEN-1:0]       i_rdata;
  logic                  d_req;
  logic                  d_we;
  logic [XLEN/8-1:0]     d_be;
  logic [ADDR_LEN-1:0]   d_addr;
  logic [XLEN-1:0]       d_wdata;
  logic                  d_gnt;
  logic                  d_rvalid;
  logic [XLEN-1:0]       d_rdata;
  logic                  ram_en;
  logic                  ram_we;
  logic [XLEN/8-1:0]     ram_be;
  logic [ADDR_LEN-3:0]   ram_addr;
  logic [XLEN-1:0]       ram_wdata;
  logic [XLEN-1:0]       ram_rdata;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_be, d_addr, d_wdata, ram_rdata,
    output i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
           ram_en, ram_we, ram_be, ram_addr, ram_wdata
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_be, d_addr, d_wdata, ram_rdata,
    input  i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
           ram_en, ram_we, ram_be, ram_addr, ram_wdata
  );
endinterface

// File: rtl/iram_arbiter.sv
// Single-port IRAM sharing between fetch and LSU: data priority with a
// starvation override for fetch, and one-cycle read return to the owner.
`ifndef RAM_BASE_ADDR_UNMASK
`define RAM_BASE_ADDR_UNMASK 32'h0000_1FFF
`endif

module iram_arbiter #(
  parameter int XLEN       = 32,
  parameter int ADDR_LEN   = 14,
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rstb,
  iram_arbiter_if.slave bus
);
  localparam logic [ADDR_LEN-1:0] UNMASK = ADDR_LEN'(`RAM_BASE_ADDR_UNMASK);
  localparam logic [3:0]          SMAX   = 4'(STARVE_MAX);

  logic [3:0]          starve_q, starve_d;
  logic                i_own_q, i_own_d;
  logic                d_own_q, d_own_d;
  logic [XLEN-1:0]     i_hold_q, d_hold_q;
  logic                i_gnt, d_gnt, en;
  logic [ADDR_LEN-1:0] masked;
  logic                unused_addr_lsb;

  // Grants are gated by reset so the RAM stays quiet while rstb is low.
  always_comb begin
    i_gnt = 1'b0;
    d_gnt = 1'b0;
    if (rstb) begin
      if (bus.i_req && (!bus.d_req || starve_q == SMAX)) i_gnt = 1'b1;
      else if (bus.d_req)                                d_gnt = 1'b1;
    end
  end

  assign en              = i_gnt | d_gnt;
  assign masked          = (i_gnt ? bus.i_addr : bus.d_addr) & UNMASK;
  assign unused_addr_lsb = ^masked[1:0];

  always_comb begin
    bus.i_gnt     = i_gnt;
    bus.d_gnt     = d_gnt;
    bus.ram_en    = en;
    bus.ram_we    = d_gnt & bus.d_we;
    bus.ram_be    = d_gnt ? bus.d_be : (i_gnt ? '1 : '0);
    bus.ram_addr  = en ? masked[ADDR_LEN-1:2] : '0;
    bus.ram_wdata = en ? bus.d_wdata : '0;
  end

  always_comb begin
    starve_d = '0;
    if (bus.i_req && !i_gnt) starve_d = (starve_q == SMAX) ? starve_q : starve_q + 4'd1;
    i_own_d  = i_gnt;
    d_own_d  = d_gnt & ~bus.d_we;
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      starve_q <= '0;
      i_own_q  <= 1'b0;
      d_own_q  <= 1'b0;
      i_hold_q <= '0;
      d_hold_q <= '0;
    end else begin
      starve_q <= starve_d;
      i_own_q  <= i_own_d;
      d_own_q  <= d_own_d;
      if (i_own_q) i_hold_q <= bus.ram_rdata;
      if (d_own_q) d_hold_q <= bus.ram_rdata;
    end
  end

  // Owner sees RAM data live on its rvalid cycle, the held copy otherwise.
  assign bus.i_rvalid = i_own_q;
  assign bus.d_rvalid = d_own_q;
  assign bus.i_rdata  = i_own_q ? bus.ram_rdata : i_hold_q;
  assign bus.d_rdata  = d_own_q ? bus.ram_rdata : d_hold_q;
endmodule

// File: tb/tb_iram_arbiter.sv
// Bench for iram_arbiter: grant/RAM-drive vector table, directed corner
// sequences, then random traffic against a cycle-level reference model.
module tb_iram_arbiter;
  localparam int XLEN = 32, ADDR_LEN = 14, STARVE_MAX = 4;

  logic clk = 1'b0;
  logic rstb = 1'b0;
  int   n_total = 0;
  int   n_pass  = 0;

  always #5 clk = ~clk;

  iram_arbiter_if #(.XLEN(XLEN), .ADDR_LEN(ADDR_LEN)) bus ();
  iram_arbiter #(.XLEN(XLEN), .ADDR_LEN(ADDR_LEN), .STARVE_MAX(STARVE_MAX))
    dut (.clk(clk), .rstb(rstb), .bus(bus));

  typedef struct {
    logic        i_req;
    logic [13:0] i_addr;
    logic        d_req;
    logic        d_we;
    logic [3:0]  d_be;
    logic [13:0] d_addr;
    logic [31:0] d_wdata;
    logic        e_ig;
    logic        e_dg;
    logic        e_en;
    logic        e_we;
    logic [3:0]  e_be;
    logic [11:0] e_addr;
    logic [31:0] e_wdata;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", name, got, exp);
    else n_pass++;
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.i_req = 0; bus.i_addr = '0; bus.d_req = 0; bus.d_we = 0;
    bus.d_be = '0; bus.d_addr = '0; bus.d_wdata = '0; bus.ram_rdata = '0;
  endtask

  task automatic do_reset();
    rstb = 1'b0;
    idle();
    nxt();
    nxt();
    rstb = 1'b1;
  endtask

  // Reference model state
  int          m_wait;
  int          m_pend;            // 0 none, 1 fetch read, 2 data read
  logic [31:0] m_ihold, m_dhold;
  logic        prev_ig, prev_dg;

  initial begin
    vecs[0] = '{0, 14'h1234, 0, 0, 4'h0, 14'h0010, 32'h0,        0, 0, 0, 0, 4'h0, 12'h000, 32'h0};
    vecs[1] = '{1, 14'h3FFC, 0, 0, 4'h0, 14'h0000, 32'hAAAA5555, 1, 0, 1, 0, 4'hF, 12'h7FF, 32'hAAAA5555};
    vecs[2] = '{0, 14'h0000, 1, 0, 4'h5, 14'h0007, 32'h0,        0, 1, 1, 0, 4'h5, 12'h001, 32'h0};
    vecs[3] = '{1, 14'h0100, 1, 1, 4'hC, 14'h1FF0, 32'hCAFEF00D, 0, 1, 1, 1, 4'hC, 12'h7FC, 32'hCAFEF00D};
    vecs[4] = '{0, 14'h0000, 1, 1, 4'hF, 14'h2004, 32'h0BADF00D, 0, 1, 1, 1, 4'hF, 12'h001, 32'h0BADF00D};
    vecs[5] = '{1, 14'h2020, 1, 0, 4'h1, 14'h3008, 32'h0,        0, 1, 1, 0, 4'h1, 12'h402, 32'h0};

    // Reset with both requests pending
    idle();
    bus.i_req = 1; bus.d_req = 1;
    @(negedge clk);
    chk("rst_i_rvalid", bus.i_rvalid, 0);
    chk("rst_d_rvalid", bus.d_rvalid, 0);
    chk("rst_ram_en",   bus.ram_en, 0);
    chk("rst_i_rdata",  bus.i_rdata, 0);
    chk("rst_d_rdata",  bus.d_rdata, 0);
    @(posedge clk); #1; rstb = 1'b1;
    @(negedge clk);
    chk("rel_d_gnt", bus.d_gnt, 1);
    chk("rel_i_gnt", bus.i_gnt, 0);
    nxt();

    // Vector table, each from a fresh reset
    foreach (vecs[k]) begin
      do_reset();
      bus.i_req = vecs[k].i_req; bus.i_addr = vecs[k].i_addr;
      bus.d_req = vecs[k].d_req; bus.d_we = vecs[k].d_we; bus.d_be = vecs[k].d_be;
      bus.d_addr = vecs[k].d_addr; bus.d_wdata = vecs[k].d_wdata;
      @(negedge clk);
      chk($sformatf("v%0d_i_gnt", k),  bus.i_gnt, vecs[k].e_ig);
      chk($sformatf("v%0d_d_gnt", k),  bus.d_gnt, vecs[k].e_dg);
      chk($sformatf("v%0d_en", k),     bus.ram_en, vecs[k].e_en);
      chk($sformatf("v%0d_we", k),     bus.ram_we, vecs[k].e_we);
      chk($sformatf("v%0d_be", k),     bus.ram_be, vecs[k].e_be);
      chk($sformatf("v%0d_addr", k),   bus.ram_addr, vecs[k].e_addr);
      chk($sformatf("v%0d_wdata", k),  bus.ram_wdata, vecs[k].e_wdata);
      nxt();
    end

    // Single fetch read and hold
    do_reset();
    bus.i_req = 1; bus.i_addr = 14'h2010;
    @(negedge clk);
    chk("sf_i_gnt", bus.i_gnt, 1);
    chk("sf_en",    bus.ram_en, 1);
    chk("sf_addr",  bus.ram_addr, 12'h004);
    nxt();
    bus.i_req = 0; bus.ram_rdata = 32'hDEADBEEF;
    @(negedge clk);
    chk("sf_i_rvalid", bus.i_rvalid, 1);
    chk("sf_i_rdata",  bus.i_rdata, 32'hDEADBEEF);
    chk("sf_d_rvalid", bus.d_rvalid, 0);
    nxt();
    bus.ram_rdata = 32'h0;
    @(negedge clk);
    chk("sf_i_rvalid_off", bus.i_rvalid, 0);
    chk("sf_i_rdata_hold", bus.i_rdata, 32'hDEADBEEF);
    nxt();

    // Data write: no read return ever
    bus.d_req = 1; bus.d_we = 1; bus.d_be = 4'b0011; bus.d_wdata = 32'h12345678; bus.d_addr = 14'h0044;
    @(negedge clk);
    chk("wr_d_gnt", bus.d_gnt, 1);
    chk("wr_we",    bus.ram_we, 1);
    chk("wr_be",    bus.ram_be, 4'b0011);
    chk("wr_wdata", bus.ram_wdata, 32'h12345678);
    nxt();
    idle();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("wr_no_d_rvalid", bus.d_rvalid, 0);
      nxt();
    end

    // Interleaved reads
    bus.d_req = 1; bus.d_addr = 14'h0040;
    @(negedge clk);
    chk("il_d_gnt", bus.d_gnt, 1);
    nxt();
    bus.d_req = 0; bus.i_req = 1; bus.i_addr = 14'h0080; bus.ram_rdata = 32'h11111111;
    @(negedge clk);
    chk("il_i_gnt",    bus.i_gnt, 1);
    chk("il_d_rvalid", bus.d_rvalid, 1);
    chk("il_i_rvalid0", bus.i_rvalid, 0);
    chk("il_d_rdata",  bus.d_rdata, 32'h11111111);
    chk("il_i_rdata_keep", bus.i_rdata, 32'hDEADBEEF);
    nxt();
    bus.i_req = 0; bus.ram_rdata = 32'h22222222;
    @(negedge clk);
    chk("il_i_rvalid", bus.i_rvalid, 1);
    chk("il_d_rvalid_off", bus.d_rvalid, 0);
    chk("il_i_rdata",  bus.i_rdata, 32'h22222222);
    chk("il_d_rdata_keep", bus.d_rdata, 32'h11111111);
    nxt();
    bus.ram_rdata = 32'h0;
    @(negedge clk);
    chk("il_i_rvalid_off", bus.i_rvalid, 0);
    chk("il_d_rvalid_off2", bus.d_rvalid, 0);
    nxt();

    // Starvation pattern with both requests held (write pending on data side)
    do_reset();
    bus.i_req = 1; bus.d_req = 1; bus.d_we = 1; bus.d_be = 4'hF;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk($sformatf("st%0d_i_gnt", k), bus.i_gnt, (k % 5) == 4);
      chk($sformatf("st%0d_d_gnt", k), bus.d_gnt, (k % 5) != 4);
      nxt();
    end

    // Counter restarts at 0 after a mid-run reset
    do_reset();
    bus.i_req = 1; bus.d_req = 1;
    nxt(); nxt(); nxt();
    rstb = 1'b0;
    nxt();
    rstb = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("cr%0d_i_gnt", k), bus.i_gnt, k == 4);
      nxt();
    end

    // Reset between fetch grant and its return
    do_reset();
    bus.i_req = 1; bus.i_addr = 14'h0010;
    @(negedge clk);
    chk("rr_i_gnt", bus.i_gnt, 1);
    rstb = 1'b0; bus.i_req = 0; bus.ram_rdata = 32'h55AA55AA;
    nxt();
    @(negedge clk);
    chk("rr_i_rvalid_rst", bus.i_rvalid, 0);
    nxt();
    rstb = 1'b1;
    @(negedge clk);
    chk("rr_i_rvalid_rel", bus.i_rvalid, 0);
    chk("rr_i_rdata_rel",  bus.i_rdata, 0);
    nxt();

    // Random traffic vs reference model
    do_reset();
    m_wait = 0; m_pend = 0; m_ihold = '0; m_dhold = '0;
    prev_ig = 1; prev_dg = 1;
    for (int c = 0; c < 1500; c++) begin
      logic        e_ig, e_dg, e_en, e_irv, e_drv;
      logic [13:0] ga;
      logic [11:0] e_addr;
      logic [3:0]  e_be;
      logic [31:0] e_ird, e_drd;
      if (!bus.i_req || prev_ig) begin
        bus.i_req = ($urandom_range(0, 2) != 0);
        bus.i_addr = 14'($urandom);
      end
      if (!bus.d_req || prev_dg) begin
        bus.d_req = ($urandom_range(0, 2) != 0);
        bus.d_we = $urandom_range(0, 1);
        bus.d_be = 4'($urandom);
        bus.d_addr = 14'($urandom);
        bus.d_wdata = $urandom;
      end
      bus.ram_rdata = $urandom;
      @(negedge clk);
      e_ig = bus.i_req && (!bus.d_req || m_wait == STARVE_MAX);
      e_dg = bus.d_req && !e_ig;
      e_en = e_ig || e_dg;
      ga = e_ig ? bus.i_addr : bus.d_addr;
      e_addr = e_en ? 12'((int'(ga) % 8192) / 4) : 12'h0;
      e_be = e_dg ? bus.d_be : (e_ig ? 4'hF : 4'h0);
      e_irv = (m_pend == 1);
      e_drv = (m_pend == 2);
      e_ird = e_irv ? bus.ram_rdata : m_ihold;
      e_drd = e_drv ? bus.ram_rdata : m_dhold;
      chk("rnd_i_gnt", bus.i_gnt, e_ig);
      chk("rnd_d_gnt", bus.d_gnt, e_dg);
      chk("rnd_en",    bus.ram_en, e_en);
      chk("rnd_we",    bus.ram_we, e_dg && bus.d_we);
      chk("rnd_be",    bus.ram_be, e_be);
      chk("rnd_addr",  bus.ram_addr, e_addr);
      if (e_en) chk("rnd_wdata", bus.ram_wdata, bus.d_wdata);
      chk("rnd_i_rvalid", bus.i_rvalid, e_irv);
      chk("rnd_d_rvalid", bus.d_rvalid, e_drv);
      chk("rnd_i_rdata",  bus.i_rdata, e_ird);
      chk("rnd_d_rdata",  bus.d_rdata, e_drd);
      m_ihold = e_ird;
      m_dhold = e_drd;
      m_pend = e_ig ? 1 : ((e_dg && !bus.d_we) ? 2 : 0);
      if (bus.i_req && !e_ig) m_wait = (m_wait < STARVE_MAX) ? m_wait + 1 : STARVE_MAX;
      else                    m_wait = 0;
      prev_ig = e_ig;
      prev_dg = e_dg;
      nxt();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/iram_arbiter.md
Name: iram_arbiter

Overview:
- Shares the single-port instruction/data RAM between the instruction-fetch port and the load/store data port.
- Default policy is data-port priority, with a starvation counter that forces a fetch grant after a bounded wait.
- Tracks which port owns each in-flight RAM read and returns the data to that port one cycle later.
- Sits between the core's fetch/LSU and the RAM macro. The ROM path is outside this block.

Parameters:
- XLEN, 32, data word width.
- ADDR_LEN, 14, byte-address width of both requester ports.
- STARVE_MAX, 4, consecutive denied fetch cycles after which fetch wins arbitration. Range 1..15.

Ports:
- clk  in  1  system clock, rising edge.
- rstb  in  1  asynchronous active-low reset.
- i_req  in  1  fetch read request; held until granted.
- i_addr  in  ADDR_LEN  fetch byte address.
- i_gnt  out  1  fetch granted this cycle (combinational).
- i_rvalid  out  1  fetch read data valid.
- i_rdata  out  XLEN  fetch read data.
- d_req  in  1  data request; held until granted.
- d_we  in  1  1 = write, 0 = read.
- d_be  in  XLEN/8  byte enables for writes.
- d_addr  in  ADDR_LEN  data byte address.
- d_wdata  in  XLEN  write data.
- d_gnt  out  1  data granted this cycle (combinational).
- d_rvalid  out  1  data read data valid (reads only).
- d_rdata  out  XLEN  data read data.
- ram_en  out  1  RAM access strobe.
- ram_we  out  1  RAM write strobe.
- ram_be  out  XLEN/8  RAM byte enables.
- ram_addr  out  ADDR_LEN-2  RAM word address.
- ram_wdata  out  XLEN  RAM write data.
- ram_rdata  in  XLEN  RAM read data, valid the cycle after a read strobe.

Behaviour:
- Clocking and reset: one clock (clk); reset is asynchronous and active-low (rstb).
- Reset values:
  - i_rvalid, d_rvalid: 0.
  - Starvation counter: 0.
  - Read-owner flags: 0.
  - i_rdata, d_rdata hold registers: 0.
  - While no request is active, ram_en, ram_we, ram_be, ram_addr and ram_wdata are 0.
- Arbitration (combinational, same cycle as request):
  - Only i_req: i_gnt=1.
  - Only d_req: d_gnt=1.
  - Both asserted: d_gnt=1, unless the starvation counter == STARVE_MAX, in which case i_gnt=1.
  - At most one grant is asserted in any cycle. No requests: no grant.
- RAM drive in the grant cycle:
  - ram_en = i_gnt | d_gnt.
  - ram_we = d_gnt & d_we.
  - ram_be = d_gnt ? d_be : all ones.
  - ram_wdata = d_wdata.
  - ram_addr = (granted addr & `RAM_BASE_ADDR_UNMASK)[ADDR_LEN-1:2]. Low two address bits are ignored.
- Starvation counter (registered):
  - Increments when i_req & !i_gnt, saturating at STARVE_MAX.
  - Clears to 0 when i_gnt=1 or i_req=0.
- Read return:
  - A granted read sets the owner flag (i_own or d_own) for exactly the next cycle.
  - i_rvalid = registered i_gnt; d_rvalid = registered (d_gnt & !d_we).
  - Latency from grant to rvalid is exactly 1 cycle. Writes never produce d_rvalid.
- Read data:
  - While the owner's rvalid=1, that port's rdata = ram_rdata (pass-through).
  - Otherwise each port's rdata holds the last value it returned, captured on the rvalid cycle.
  - The non-owning port's rdata is unchanged.
- Back-to-back: a new grant is permitted every cycle, including the cycle in which a previous read's rvalid is asserted. Throughput is 1 access per cycle.
- Simultaneous starvation and write: if the counter == STARVE_MAX while a data write is pending, fetch still wins and the write waits 1 cycle. The counter then clears.
- Reset mid-operation: in-flight reads are discarded, no rvalid is issued after rstb deasserts, and the counter restarts at 0.

Test Plan:
- Reset: assert rstb=0 with both reqs high → all rvalid=0, ram_en=0, rdata=0. Release → first cycle d_gnt=1, i_gnt=0.
- Single fetch: i_req, i_addr=0x2010 with `RAM_BASE_ADDR_UNMASK` clearing the region bit → same cycle i_gnt=1, ram_en=1, ram_addr=0x004. Next cycle i_rvalid=1, i_rdata=ram_rdata (0xDEADBEEF); i_rdata holds 0xDEADBEEF afterwards.
- Data write: d_req, d_we=1, d_be=4'b0011, d_wdata=0x12345678 → ram_we=1, ram_be=4'b0011, no d_rvalid in any later cycle.
- Starvation, STARVE_MAX=4: both reqs held continuously → d_gnt on cycles 0-3, i_gnt on cycle 4, d_gnt on cycle 5. Pattern repeats every 5 cycles.
- Interleaved reads: d read at cycle 0, fetch at cycle 1 → d_rvalid at cycle 1 only, i_rvalid at cycle 2 only. Each rdata matches its own RAM word; the other port's rdata is unchanged.
- Reset during read: grant a fetch, pull rstb low before the next edge → i_rvalid is never asserted and the counter reads 0 after release.
